// File: rtl/ISO14443A_pkg.sv
// Shared types and defaults for the ISO14443A receive path.
package ISO14443A_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRx,
    StDiscard,
    StDrain,
    StDone
  } RxFrameState;

  localparam int unsigned DefaultMaxBytes  = 64;
  localparam int unsigned DefaultFifoDepth = 4;

  // One FIFO entry carries {data_bits, data}.
  localparam int unsigned RxEntryWidth = 11;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous FIFO with full/empty flags and a flush that empties it in one cycle.
module rx_fifo #(
  parameter int unsigned Width = 11,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0] PtrOne = 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wptr_q, rptr_q;

  // Extra pointer bit tells full from empty when the addresses match.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                 (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign rdata = mem_q[rptr_q[AddrW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push && !full) begin
        mem_q[wptr_q[AddrW-1:0]] <= wdata;
        wptr_q <= wptr_q + PtrOne;
      end
      if (pop && !empty) begin
        rptr_q <= rptr_q + PtrOne;
      end
    end
  end

endmodule

// File: rtl/rx_frame_controller.sv
// Frames decoded bytes into a buffered stream for the upper layer and reports
// per-frame completion, error and byte count.
module rx_frame_controller
  import ISO14443A_pkg::*;
#(
  parameter int unsigned MAX_BYTES  = DefaultMaxBytes,
  parameter int unsigned FIFO_DEPTH = DefaultFifoDepth
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_enable,
  input  logic       soc,
  input  logic       eoc,
  input  logic [7:0] data,
  input  logic [2:0] data_bits,
  input  logic       data_valid,
  input  logic       sequence_error,
  input  logic       parity_error,
  output logic [7:0] rx_data,
  output logic [2:0] rx_data_bits,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_done,
  output logic       frame_error,
  output logic [7:0] frame_byte_count
);

  localparam logic [7:0] MaxCount = 8'(MAX_BYTES);

  RxFrameState state_q;
  logic [7:0]  cnt_q;
  logic        err_q;
  logic        frame_done_q, frame_error_q;
  logic [7:0]  frame_count_q;

  logic [RxEntryWidth-1:0] fifo_rdata;
  logic fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic abort, rx_fault;

  // A new soc while a frame is open ends that frame as an error.
  assign abort    = soc && (state_q inside {StRx, StDiscard, StDrain});
  assign rx_fault = (state_q == StRx) &&
                    (sequence_error || parity_error ||
                     (data_valid && (fifo_full || (cnt_q == MaxCount))));
  assign fifo_push = (state_q == StRx) && data_valid && !rx_fault && !soc;
  assign fifo_pop  = !fifo_empty && rx_ready;

  rx_fifo #(
    .Width(RxEntryWidth),
    .Depth(FIFO_DEPTH)
  ) u_rx_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(abort),
    .push (fifo_push),
    .wdata({data_bits, data}),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign rx_valid         = !fifo_empty;
  assign rx_data          = fifo_rdata[7:0];
  assign rx_data_bits     = fifo_rdata[10:8];
  assign frame_done       = frame_done_q;
  assign frame_error      = frame_error_q;
  assign frame_byte_count = frame_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (abort) begin
        frame_done_q  <= 1'b1;
        frame_error_q <= 1'b1;
        frame_count_q <= cnt_q;
        cnt_q         <= '0;
        err_q         <= 1'b0;
        state_q       <= rx_enable ? StRx : StIdle;
      end else begin
        unique case (state_q)
          StIdle, StDone: begin
            if (soc && rx_enable) begin
              state_q <= StRx;
              cnt_q   <= '0;
              err_q   <= 1'b0;
            end else begin
              state_q <= StIdle;
            end
          end
          StRx: begin
            // The fault check keeps cnt_q from ever passing MaxCount.
            if (rx_fault) begin
              err_q   <= 1'b1;
              state_q <= StDiscard;
            end else if (data_valid) begin
              cnt_q <= cnt_q + 8'd1;
            end
            if (eoc) begin
              state_q <= StDrain;
            end
          end
          StDiscard: begin
            if (eoc) begin
              state_q <= StDrain;
            end
          end
          StDrain: begin
            if (fifo_empty) begin
              state_q       <= StDone;
              frame_done_q  <= 1'b1;
              frame_error_q <= err_q || (cnt_q == 8'd0);
              frame_count_q <= cnt_q;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_controller.sv
// Randomised and directed bench for rx_frame_controller against a frame-level model.
module tb_rx_frame_controller;

  localparam int unsigned MaxB  = 8;
  localparam int unsigned Depth = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_enable = 1'b0, soc = 1'b0, eoc = 1'b0, data_valid = 1'b0;
  logic       sequence_error = 1'b0, parity_error = 1'b0, rx_ready = 1'b0;
  logic [7:0] data = '0;
  logic [2:0] data_bits = '0;
  logic [7:0] rx_data, frame_byte_count;
  logic [2:0] rx_data_bits;
  logic       rx_valid, frame_done, frame_error;

  always #5 clk = ~clk;

  rx_frame_controller #(
    .MAX_BYTES (MaxB),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx_enable       (rx_enable),
    .soc             (soc),
    .eoc             (eoc),
    .data            (data),
    .data_bits       (data_bits),
    .data_valid      (data_valid),
    .sequence_error  (sequence_error),
    .parity_error    (parity_error),
    .rx_data         (rx_data),
    .rx_data_bits    (rx_data_bits),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .frame_done      (frame_done),
    .frame_error     (frame_error),
    .frame_byte_count(frame_byte_count)
  );

  int n_cmp = 0;
  int n_fail = 0;
  bit rand_ready = 1'b0;

  // Frame-level model: queue of bytes the upper layer must see, plus frame status.
  logic [10:0] mq[$];
  bit m_active, m_drop, m_drain, m_done, m_err, m_err_out;
  int m_cnt, m_count_out;

  logic [10:0] byte_log[$];
  logic [8:0]  done_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_active = 0; m_drop = 0; m_drain = 0; m_done = 0; m_err = 0; m_err_out = 0;
      m_cnt = 0; m_count_out = 0;
    end else begin
      automatic bit pop_now  = (mq.size() > 0) && rx_ready;
      automatic bit full_now = (mq.size() == Depth);
      automatic bit empty_now = (mq.size() == 0);
      m_done = 0;
      if (soc && (m_active || m_drain)) begin
        mq.delete();
        m_done = 1; m_err_out = 1; m_count_out = m_cnt;
        m_cnt = 0; m_err = 0; m_drop = 0; m_drain = 0;
        m_active = rx_enable;
      end else begin
        if (pop_now) void'(mq.pop_front());
        if (m_active) begin
          if (!m_drop) begin
            if (sequence_error || parity_error ||
                (data_valid && (full_now || m_cnt == MaxB))) begin
              m_err = 1; m_drop = 1;
            end else if (data_valid) begin
              mq.push_back({data_bits, data});
              m_cnt++;
            end
          end
          if (eoc) begin
            m_active = 0; m_drain = 1;
          end
        end else if (m_drain) begin
          if (empty_now) begin
            m_done = 1; m_err_out = m_err || (m_cnt == 0); m_count_out = m_cnt;
            m_drain = 0;
          end
        end else if (soc && rx_enable) begin
          m_active = 1; m_drop = 0; m_cnt = 0; m_err = 0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("rx_valid", 32'(rx_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) chk("rx_byte", 32'({rx_data_bits, rx_data}), 32'(mq[0]));
      chk("frame_done", 32'(frame_done), 32'(m_done));
      if (m_done) chk("frame_error", 32'(frame_error), 32'(m_err_out));
      chk("frame_byte_count", 32'(frame_byte_count), 32'(m_count_out));
      if (rx_valid && rx_ready) byte_log.push_back({rx_data_bits, rx_data});
      if (frame_done) done_log.push_back({frame_error, frame_byte_count});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) rx_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic cyc(input bit s, input bit e, input bit dv, input logic [7:0] d,
                     input logic [2:0] b, input bit pe, input bit se);
    soc = s; eoc = e; data_valid = dv; data = d; data_bits = b;
    parity_error = pe; sequence_error = se;
    tick();
    soc = 0; eoc = 0; data_valid = 0; parity_error = 0; sequence_error = 0;
  endtask

  task automatic wait_quiet(input string name);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (!m_active && !m_drain && !m_done && mq.size() == 0) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: frame still open after 400 cycles", name);
    end
    tick(); tick();
  endtask

  task automatic clear_logs();
    byte_log.delete();
    done_log.delete();
  endtask

  task automatic chk_done(input string name, input int idx, input bit err, input int cnt);
    chk({name, "_done"}, (done_log.size() > idx) ? 32'(done_log[idx]) : 32'hdead,
        32'({err, 8'(cnt)}));
  endtask

  task automatic chk_byte(input string name, input int idx, input logic [10:0] v);
    chk({name, "_byte"}, (byte_log.size() > idx) ? 32'(byte_log[idx]) : 32'hdead, 32'(v));
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_frame_error", 32'(frame_error), 0);
    chk("rst_count", 32'(frame_byte_count), 0);
    chk("rst_rx_byte", 32'({rx_data_bits, rx_data}), 0);
    rst_n = 1;
    tick();

    // Single good byte.
    rx_enable = 1; rx_ready = 1; clear_logs();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 8'h29, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    wait_quiet("t1");
    chk("t1_nbytes", byte_log.size(), 1); chk_byte("t1", 0, 11'h029);
    chk("t1_ndone", done_log.size(), 1); chk_done("t1", 0, 0, 1);

    // Parity error on the second byte.
    clear_logs();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 8'h11, 0, 0, 0);
    cyc(0, 0, 1, 8'h22, 0, 1, 0);
    cyc(0, 0, 1, 8'h33, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    wait_quiet("t2");
    chk("t2_nbytes", byte_log.size(), 1); chk_byte("t2", 0, 11'h011);
    chk_done("t2", 0, 1, 1);

    // Overflow with a stalled consumer.
    clear_logs(); rx_ready = 0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 8'(8'h40 + i), 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("t3_stall_valid", 32'(rx_valid), 1);
    chk("t3_stall_byte", 32'({rx_data_bits, rx_data}), 32'h040);
    chk("t3_no_done_yet", done_log.size(), 0);
    rx_ready = 1;
    wait_quiet("t3");
    chk("t3_nbytes", byte_log.size(), 4); chk_byte("t3", 3, 11'h043);
    chk_done("t3", 0, 1, 4);

    // Partial last byte coincident with eoc.
    clear_logs();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 8'hA5, 0, 0, 0);
    cyc(0, 1, 1, 8'h03, 3'd4, 0, 0);
    wait_quiet("t4");
    chk_byte("t4a", 0, 11'h0A5); chk_byte("t4b", 1, 11'h403);
    chk_done("t4", 0, 0, 2);

    // soc ignored while disabled; disabling after soc keeps the frame.
    clear_logs(); rx_enable = 0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 8'h99, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    wait_quiet("t5a");
    chk("t5a_nbytes", byte_log.size(), 0); chk("t5a_ndone", done_log.size(), 0);
    rx_enable = 1;
    cyc(1, 0, 0, 0, 0, 0, 0);
    rx_enable = 0;
    cyc(0, 0, 1, 8'h5A, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    wait_quiet("t5b");
    chk_byte("t5b", 0, 11'h05A); chk_done("t5b", 0, 0, 1);

    // soc mid-frame aborts and starts a clean frame.
    clear_logs(); rx_enable = 1; rx_ready = 0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 8'h01, 0, 0, 0);
    cyc(0, 0, 1, 8'h02, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 8'h77, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    rx_ready = 1;
    wait_quiet("t6");
    chk("t6_nbytes", byte_log.size(), 1); chk_byte("t6", 0, 11'h077);
    chk_done("t6a", 0, 1, 2); chk_done("t6b", 1, 0, 1);

    // Byte limit: one byte past MaxB.
    clear_logs();
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i <= MaxB; i++) cyc(0, 0, 1, 8'(i), 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    wait_quiet("t7");
    chk("t7_nbytes", byte_log.size(), MaxB); chk_done("t7", 0, 1, MaxB);

    // Empty frame.
    clear_logs();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    wait_quiet("t8");
    chk_done("t8", 0, 1, 0);

    // Reset mid-frame is silent.
    clear_logs(); rx_ready = 0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 8'hC3, 0, 0, 0);
    cyc(0, 0, 1, 8'hC4, 0, 0, 0);
    rst_n = 0; #1;
    chk("t9_rst_valid", 32'(rx_valid), 0);
    chk("t9_rst_done", 32'(frame_done), 0);
    chk("t9_rst_count", 32'(frame_byte_count), 0);
    chk("t9_rst_byte", 32'({rx_data_bits, rx_data}), 0);
    tick(); rst_n = 1; rx_ready = 1;
    cyc(0, 1, 1, 8'hEE, 0, 0, 0);
    repeat (4) tick();
    chk("t9_nbytes", byte_log.size(), 0); chk("t9_ndone", done_log.size(), 0);

    // Random frames; the per-cycle compare carries the checking.
    rand_ready = 1;
    for (int f = 0; f < 60; f++) begin
      automatic int n = $urandom_range(0, 10);
      rx_enable = ($urandom_range(0, 7) != 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < n; i++) begin
        automatic bit last = (i == n - 1) && ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 3) == 0) tick();
        if ($urandom_range(0, 9) == 0) rx_enable = ~rx_enable;
        if ($urandom_range(0, 24) == 0) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, last, 1, 8'($urandom), last ? 3'($urandom_range(1, 7)) : 3'd0,
            ($urandom_range(0, 24) == 0), ($urandom_range(0, 39) == 0));
        if (last) break;
      end
      cyc(0, 1, 0, 0, 0, 0, 0);
      wait_quiet("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
